// File: rtl/rename_dispatch_queue.sv
// In-order rename-to-dispatch buffer: compacts sparse rename lanes on enqueue and
// presents the oldest entries first-word-fall-through to dispatch, which takes a prefix.
module rename_dispatch_queue #(
  parameter int RENAME_WIDTH   = 4,
  parameter int DISPATCH_WIDTH = 4,
  parameter int DEPTH          = 16,
  parameter int UOP_W          = 128,
  parameter int CNT_W          = $clog2(DEPTH + 1),
  parameter int TAKE_W         = $clog2(DISPATCH_WIDTH + 1)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [RENAME_WIDTH-1:0]           in_valid,
  input  logic [RENAME_WIDTH*UOP_W-1:0]     in_uop,
  output logic                              in_ready,
  output logic [DISPATCH_WIDTH-1:0]         out_valid,
  output logic [DISPATCH_WIDTH*UOP_W-1:0]   out_uop,
  input  logic [TAKE_W-1:0]                 out_take,
  output logic [CNT_W-1:0]                  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [UOP_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W-1:0] waddr [RENAME_WIDTH];
  logic [CNT_W-1:0] n_in, n_out, n_avail;
  logic             enq_fire;

  assign in_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(RENAME_WIDTH);
  assign enq_fire = in_ready && (|in_valid);

  // Each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    n_in = '0;
    for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
      waddr[i] = tail + PTR_W'(n_in);
      if (in_valid[i]) n_in = n_in + CNT_W'(1);
    end
  end

  always_comb begin
    n_avail = (count < CNT_W'(DISPATCH_WIDTH)) ? count : CNT_W'(DISPATCH_WIDTH);
    n_out   = (CNT_W'(out_take) < n_avail) ? CNT_W'(out_take) : n_avail;
  end

  always_comb begin
    out_valid = '0;
    out_uop   = '0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      out_valid[i]             = CNT_W'(i) < count;
      out_uop[i*UOP_W +: UOP_W] = mem[head + PTR_W'(i)];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) tail <= tail + PTR_W'(n_in);
      head  <= head + PTR_W'(n_out);
      count <= count + (enq_fire ? n_in : '0) - n_out;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush && enq_fire) begin
      for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
        if (in_valid[i]) mem[waddr[i]] <= in_uop[i*UOP_W +: UOP_W];
      end
    end
  end

  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    count <= CNT_W'(DEPTH));
  a_valid_prefix: assert property (@(posedge clock) disable iff (reset)
    ((out_valid + DISPATCH_WIDTH'(1)) & out_valid) == '0);
  a_take_bound: assert property (@(posedge clock) disable iff (reset)
    out_take <= TAKE_W'(DISPATCH_WIDTH));

endmodule
